// File: rtl/spi_cmd_decoder.sv
// Byte-oriented command decoder behind an SPI slave: drives four BCD display digits,
// a colon/decimal-point selector and a saturating protocol error counter, one reply per byte.
module spi_cmd_decoder #(
    parameter int TIMEOUT = 16000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [1:0] colon,
    output logic [7:0] err_cnt
);

    localparam int              CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [7:0]      ACK      = 8'hA5;
    localparam logic [7:0]      NAK      = 8'hEE;

    typedef enum logic [1:0] {IDLE, PAY1, PAY2} state_t;

    state_t         state_q, state_d;
    logic [7:0]     cmd_q, cmd_d;
    logic [7:0]     hold_q, hold_d;
    logic [15:0]    dig_q, dig_d;
    logic [1:0]     colon_q, colon_d;
    logic [7:0]     tx_byte_q, tx_byte_d;
    logic           tx_valid_q, tx_valid_d;
    logic [7:0]     err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_inc;

    // SET_ALL commit word: held high byte plus the incoming low byte
    logic [15:0]    pay2_word;
    logic [3:0]     pay2_ok;
    logic [15:0]    dig_inc;
    logic [3:0]     inc_carry;

    assign pay2_word    = {hold_q, rx_byte};
    assign inc_carry[0] = 1'b1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
        logic wrap;
        assign pay2_ok[gi] = (pay2_word[gi*4 +: 4] <= 4'd9);
        assign wrap        = (dig_q[gi*4 +: 4] == 4'd9);
        assign dig_inc[gi*4 +: 4] = inc_carry[gi] ? (wrap ? 4'd0 : dig_q[gi*4 +: 4] + 4'd1)
                                                  : dig_q[gi*4 +: 4];
        if (gi < 3) begin : g_carry
            assign inc_carry[gi+1] = inc_carry[gi] & wrap;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        hold_d     = hold_q;
        dig_d      = dig_q;
        colon_d    = colon_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = 1'b0;
        cnt_d      = cnt_q;
        err_inc    = 1'b0;

        if (rx_ready) begin
            cnt_d      = '0;
            tx_valid_d = 1'b1;
            tx_byte_d  = ACK;
            case (state_q)
                IDLE: begin
                    case (rx_byte)
                        8'h00: ;
                        8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h30: begin
                            cmd_d   = rx_byte;
                            state_d = PAY1;
                        end
                        8'h40: dig_d = dig_inc;
                        8'h50: tx_byte_d = err_q;
                        8'h51: tx_byte_d = dig_q[15:8];
                        8'h52: tx_byte_d = dig_q[7:0];
                        default: begin
                            tx_byte_d = NAK;
                            err_inc   = 1'b1;
                        end
                    endcase
                end
                PAY1: begin
                    if (cmd_q == 8'h20) begin
                        hold_d  = rx_byte;
                        state_d = PAY2;
                    end else begin
                        state_d = IDLE;
                        if (cmd_q == 8'h30) begin
                            colon_d = rx_byte[1:0];
                        end else if (rx_byte[3:0] <= 4'd9) begin
                            dig_d[{cmd_q[1:0], 2'b00} +: 4] = rx_byte[3:0];
                        end else begin
                            tx_byte_d = NAK;
                            err_inc   = 1'b1;
                        end
                    end
                end
                PAY2: begin
                    state_d = IDLE;
                    hold_d  = '0;
                    if (&pay2_ok) begin
                        dig_d = pay2_word;
                    end else begin
                        tx_byte_d = NAK;
                        err_inc   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // A silent timeout abandons the command without a reply
            if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                hold_d  = '0;
                err_inc = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            hold_q     <= '0;
            dig_q      <= '0;
            colon_q    <= 2'b11;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            hold_q     <= hold_d;
            dig_q      <= dig_d;
            colon_q    <= colon_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign tx_byte  = tx_byte_q;
    assign tx_valid = tx_valid_q;
    assign digit0   = dig_q[3:0];
    assign digit1   = dig_q[7:4];
    assign digit2   = dig_q[11:8];
    assign digit3   = dig_q[15:12];
    assign colon    = colon_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed scenarios plus random command traffic,
// compared every cycle against a decimal-value reference model.
module tb_spi_cmd_decoder;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [1:0] colon;
    logic [7:0] err_cnt;

    int total = 0;
    int bad = 0;
    int txn = 0;

    spi_cmd_decoder #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_ready(rx_ready),
        .tx_byte(tx_byte), .tx_valid(tx_valid),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .colon(colon), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: display held as an integer 0..9999, open command as a byte queue
    int         m_val;
    logic [1:0] m_colon;
    logic [7:0] m_tx;
    logic [7:0] m_err;
    logic       m_valid;
    logic [7:0] m_pend[$];
    int         m_wait;

    function automatic int p10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int dig(input int n);
        return (m_val / p10(n)) % 10;
    endfunction

    function automatic logic [15:0] m_digits();
        logic [15:0] w;
        for (int i = 0; i < 4; i++) w[i*4 +: 4] = 4'(dig(i));
        return w;
    endfunction

    task automatic m_error();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    task automatic m_reset();
        m_val = 0; m_colon = 2'b11; m_tx = 8'h00; m_err = 8'h00;
        m_valid = 1'b0; m_pend.delete(); m_wait = 0;
    endtask

    task automatic m_update(input logic rdy, input logic [7:0] b);
        logic [7:0] c, h;
        m_valid = 1'b0;
        if (rdy) begin
            m_valid = 1'b1;
            m_wait = 0;
            m_tx = 8'hA5;
            if (m_pend.size() == 0) begin
                if (b == 8'h00) begin
                end else if ((b >= 8'h10 && b <= 8'h13) || b == 8'h20 || b == 8'h30) begin
                    m_pend.push_back(b);
                end else if (b == 8'h40) begin
                    m_val = (m_val + 1) % 10000;
                end else if (b == 8'h50) begin
                    m_tx = m_err;
                end else if (b == 8'h51) begin
                    m_tx = 8'(dig(3) * 16 + dig(2));
                end else if (b == 8'h52) begin
                    m_tx = 8'(dig(1) * 16 + dig(0));
                end else begin
                    m_tx = 8'hEE; m_error();
                end
            end else if (m_pend[0] == 8'h20 && m_pend.size() == 1) begin
                m_pend.push_back(b);
            end else begin
                c = m_pend[0];
                if (c == 8'h20) begin
                    h = m_pend[1];
                    if (h[7:4] <= 9 && h[3:0] <= 9 && b[7:4] <= 9 && b[3:0] <= 9)
                        m_val = int'(h[7:4]) * 1000 + int'(h[3:0]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
                    else begin
                        m_tx = 8'hEE; m_error();
                    end
                end else if (c == 8'h30) begin
                    m_colon = b[1:0];
                end else if (b[3:0] <= 9) begin
                    m_val = m_val + (int'(b[3:0]) - dig(int'(c[1:0]))) * p10(int'(c[1:0]));
                end else begin
                    m_tx = 8'hEE; m_error();
                end
                m_pend.delete();
            end
        end else if (m_pend.size() != 0) begin
            m_wait++;
            if (m_wait == TO) begin
                m_pend.delete(); m_wait = 0; m_error();
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        check({where, ":tx_valid"}, 16'(tx_valid), 16'(m_valid));
        check({where, ":tx_byte"},  16'(tx_byte),  16'(m_tx));
        check({where, ":digits"},   {digit3, digit2, digit1, digit0}, m_digits());
        check({where, ":colon"},    16'(colon),    16'(m_colon));
        check({where, ":err_cnt"},  16'(err_cnt),  16'(m_err));
    endtask

    task automatic step(input logic rdy, input logic [7:0] b);
        rx_ready = rdy;
        rx_byte  = b;
        m_update(rdy, b);
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        if (rdy) begin
            txn++;
            $display("txn %0d rx=%02h tx_valid=%0b tx=%02h digits=%h%h%h%h err=%0d",
                     txn, b, tx_valid, tx_byte, digit3, digit2, digit1, digit0, err_cnt);
        end
        check_all(rdy ? "byte" : "idle");
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_ready = 1'b1;
        rx_byte = 8'h40;
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        rx_ready = 1'b0;
        $display("txn reset tx=%02h digits=%h%h%h%h err=%0d", tx_byte, digit3, digit2, digit1, digit0, err_cnt);
        check_all("reset");
    endtask

    logic [7:0] cmd_tab [16] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h30, 8'h40,
                                 8'h50, 8'h51, 8'h52, 8'h14, 8'h1F, 8'h7F, 8'h21, 8'h53};

    initial begin
        logic [7:0] b;
        int gap;
        m_reset();
        do_reset();

        // SET_DIGIT 2 <- 7
        send(8'h12); send(8'h07);
        check("set_digit2", 16'(digit2), 16'd7);

        // SET_ALL with a bad low nibble: rejected wholesale
        send(8'h20); send(8'h12); send(8'h3A);
        check("setall_bad_err", 16'(err_cnt), 16'd1);

        // 9999 then INC wraps to 0000
        send(8'h20); send(8'h99); send(8'h99);
        send(8'h40);
        check("inc_wrap", {digit3, digit2, digit1, digit0}, 16'h0000);

        // SET_COLON keeps the raw two bits, including 2'b10
        send(8'h30); send(8'hFE);
        check("colon_10", 16'(colon), 16'b10);

        // Load 1234, then SET_ALL abandoned by timeout
        send(8'h20); send(8'h12); send(8'h34);
        send(8'h20); wait_cycles(TO - 1);
        check("no_timeout_yet", 16'(err_cnt), 16'd1);
        wait_cycles(1);
        check("timeout_err", 16'(err_cnt), 16'd2);
        send(8'h51);
        check("read_hi_after_to", 16'(tx_byte), 16'h12);

        // Payload on cycle TO-1 and on the timeout cycle itself are both accepted
        send(8'h11); wait_cycles(TO - 2); send(8'h05);
        check("late_payload_d1", 16'(digit1), 16'd5);
        send(8'h10); wait_cycles(TO - 1); send(8'h08);
        check("edge_payload_d0", 16'(digit0), 16'd8);
        check("edge_payload_err", 16'(err_cnt), 16'd2);
        send(8'h52);

        // Random traffic with occasional long gaps
        for (int i = 0; i < 500; i++) begin
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 2);
            wait_cycles(gap);
            if (m_pend.size() == 0) begin
                b = cmd_tab[$urandom_range(0, 15)];
            end else if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom_range(0, 255));
            end else begin
                b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            send(b);
        end

        // Saturation
        for (int i = 0; i < 256; i++) send(8'h7F);
        check("err_saturate", 16'(err_cnt), 16'd255);
        send(8'h7F);
        check("err_no_wrap", 16'(err_cnt), 16'd255);

        // Reset in the middle of SET_ALL, then decode fresh commands
        send(8'h20); send(8'h98);
        do_reset();
        send(8'h51);
        check("post_reset_read", 16'(tx_byte), 16'h00);
        send(8'h00);
        check("post_reset_ack", 16'(tx_byte), 16'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
